fx2_slave_fifo: RTL
===================

# fx2_slave_fifo

Synthesizable model of the FX2 (CY7C68013) synchronous slave-FIFO endpoint pair: the device side of the USB_FD/SLRD/SLWR/SLOE/SLCS/FIFOADR/FLAGx bus that the FPGA USB master drives. It buffers host-to-FPGA data in EP2 (OUT) and FPGA-to-host data in EP6 (IN), drives the three FX2 flags, and exposes a valid/ready host-side port for each endpoint. It replaces hand-toggled flags in loopback benches and acts as a bridge in on-chip loopback builds.

## Interface
Parameters:
- DW, 16, FD word width
- DEPTH, 512, words per endpoint buffer (power of 2)
- PF_LEVEL, 448, EP6 programmable-full threshold in words

Ports:
- FPGA_GCLK1  in  1  IFCLK; all logic on rising edge
- CPU_RESET  in  1  asynchronous, active-low reset
- USB_FIFOADR  in  2  endpoint select: 00=EP2, 01=EP4, 10=EP6, 11=EP8
- USB_SLCS  in  1  chip select, active-low
- USB_SLOE  in  1  output enable, active-low
- USB_SLRD  in  1  read strobe, active-low
- USB_SLWR  in  1  write strobe, active-low
- USB_FD  inout  DW  data bus
- USB_FLAGA  out  1  EP6 programmable-full, active-low (0 when EP6 count >= PF_LEVEL)
- USB_FLAGB  out  1  EP6 full, active-low
- USB_FLAGC  out  1  EP2 empty, active-low
- HOST_OUT_DATA / HOST_OUT_VALID  in  DW / 1  host word into EP2
- HOST_OUT_READY  out  1  EP2 not full
- HOST_IN_DATA / HOST_IN_VALID  out  DW / 1  EP6 head word to host
- HOST_IN_READY  in  1  host accepts EP6 head
- ERR_STATUS  out  3  sticky {addr_err, underrun, overrun}

## Operation
- EP2 pop: SLCS=0, SLRD=0, FIFOADR=00 at a rising edge and EP2 not empty → head word removed.
- EP6 push: SLCS=0, SLWR=0, FIFOADR=10 at a rising edge and EP6 not full → USB_FD captured.
- FD drive: USB_FD = EP2 head word while SLCS=0, SLOE=0, FIFOADR=00; high-Z otherwise. EP2 empty with FD enabled drives 16'h0000.
- Host side: EP2 push on HOST_OUT_VALID & HOST_OUT_READY; EP6 pop on HOST_IN_VALID & HOST_IN_READY.
- Pop of empty EP2 (SLRD=0): ignored, underrun set. Push to full EP6 (SLWR=0): word dropped, overrun set.
- SLRD=0 or SLWR=0 with FIFOADR 01/11 (SLCS=0): no effect, addr_err set. SLRD and SLWR both low: both act on their own addressed endpoint only; a strobe whose FIFOADR mismatches its direction (SLRD with 10, SLWR with 00) sets addr_err.
- SLCS=1: all strobes ignored, FD high-Z.
- Simultaneous push and pop on one endpoint: both occur, count unchanged; when full, the same-edge pop makes room, so the push succeeds; when empty, the pop is an underrun and the push proceeds.
- ERR_STATUS bits clear only on reset.

## Timing
- Reset (async assert, sync-release on clock edge): both buffers empty; USB_FLAGA=1, USB_FLAGB=1, USB_FLAGC=0, HOST_OUT_READY=1, HOST_IN_VALID=0, HOST_IN_DATA=0, ERR_STATUS=0, FD high-Z. Reset mid-transfer discards buffered data.
- Buffers are first-word-fall-through: after the edge that pops, FD/HOST_IN_DATA shows the next word in the same cycle.
- Write-to-visibility: a word pushed at edge k is on FD (EP2) / HOST_IN_VALID=1 (EP6) after edge k.
- Flags registered from post-update counts: change after the same edge as the causing push/pop (0-cycle lag vs count). FLAGC goes 1 after the edge of the first EP2 push; FLAGB goes 0 after the edge filling the DEPTH-th EP6 word.
- Counts are log2(DEPTH)+1 bits; pointers wrap modulo DEPTH.

## Structure
- Package usb_fx2_pkg: FIFOADR encodings (EP2/EP4/EP6/EP8), ERR_STATUS bit indices.
- One sub-module usb_sfifo (FWFT sync FIFO, push/pop/full/empty/count), instantiated for EP2 and EP6; the top holds strobe decode, FD tri-state, flags, and error bits.

## Test plan
- Reset: CPU_RESET=0 → FLAGA=1, FLAGB=1, FLAGC=0, FD=Z, ERR_STATUS=0.
- EP2 path: host pushes 16'h0001..16'h0004; FPGA side SLOE=0, FIFOADR=00, SLRD=0 for 4 cycles → FD reads 1,2,3,4 in order, FLAGC=0 after the 4th pop edge.
- EP6 fill: HOST_IN_READY=0, 512 SLWR writes → FLAGA=0 after the 448th, FLAGB=0 after the 512th; 513th write sets overrun; host then drains 512 words in order.
- Simultaneous: EP6 full, SLWR=0 and host pop on the same edge → count stays 512, no overrun, new word at tail.
- Errors: SLRD=0 on empty EP2 → underrun; SLWR=0 with FIFOADR=01 → addr_err, counts unchanged.
- Async reset mid-burst: assert CPU_RESET=0 during a 10-word EP2 read → buffers empty, flags at reset values immediately.

Source files
------------

// File: rtl/usb_fx2_pkg.sv
// Shared encodings for the FX2 slave-FIFO model: FIFOADR endpoint codes and
// the layout of the sticky error status.
package usb_fx2_pkg;

  localparam logic [1:0] FifoAdrEp2 = 2'b00;
  localparam logic [1:0] FifoAdrEp4 = 2'b01;
  localparam logic [1:0] FifoAdrEp6 = 2'b10;
  localparam logic [1:0] FifoAdrEp8 = 2'b11;

  localparam int unsigned ErrOverrunBit  = 0;
  localparam int unsigned ErrUnderrunBit = 1;
  localparam int unsigned ErrAddrBit     = 2;

  typedef struct packed {
    logic addr_err;
    logic underrun;
    logic overrun;
  } err_t;

endpackage

// File: rtl/usb_sfifo.sv
// First-word-fall-through synchronous FIFO. A pop on a full FIFO frees room for a
// push on the same edge; a pop on an empty FIFO is ignored.
module usb_sfifo #(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 512,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign count   = count_q;
  // Empty head reads as zero so nothing undefined leaks onto the buses.
  assign rdata   = empty ? '0 : mem[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fx2_slave_fifo.sv
// FX2 slave-FIFO device model: EP2 (host to FPGA) and EP6 (FPGA to host) buffers,
// FIFOADR/strobe decode, FD tri-state, FLAGA/B/C and sticky error bits.
module fx2_slave_fifo
  import usb_fx2_pkg::*;
#(
  parameter int unsigned DW       = 16,
  parameter int unsigned DEPTH    = 512,
  parameter int unsigned PF_LEVEL = 448
) (
  input  logic          FPGA_GCLK1,
  input  logic          CPU_RESET,
  input  logic [1:0]    USB_FIFOADR,
  input  logic          USB_SLCS,
  input  logic          USB_SLOE,
  input  logic          USB_SLRD,
  input  logic          USB_SLWR,
  inout  wire  [DW-1:0] USB_FD,
  output logic          USB_FLAGA,
  output logic          USB_FLAGB,
  output logic          USB_FLAGC,
  input  logic [DW-1:0] HOST_OUT_DATA,
  input  logic          HOST_OUT_VALID,
  output logic          HOST_OUT_READY,
  output logic [DW-1:0] HOST_IN_DATA,
  output logic          HOST_IN_VALID,
  input  logic          HOST_IN_READY,
  output logic [2:0]    ERR_STATUS
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] PfLevel = CW'(PF_LEVEL);

  logic          cs_act, rd_act, wr_act, adr_ep2, adr_ep6, fd_oe;
  logic          ep2_push, ep2_pop_req, ep2_full, ep2_empty;
  logic          ep6_push_req, ep6_pop, ep6_full, ep6_empty;
  logic [CW-1:0] ep2_count, ep6_count;
  logic [DW-1:0] ep2_head;
  logic          underrun_set, overrun_set, addr_set;
  err_t          err_q;

  assign cs_act  = !USB_SLCS;
  assign rd_act  = cs_act && !USB_SLRD;
  assign wr_act  = cs_act && !USB_SLWR;
  assign adr_ep2 = (USB_FIFOADR == FifoAdrEp2);
  assign adr_ep6 = (USB_FIFOADR == FifoAdrEp6);

  assign ep2_pop_req  = rd_act && adr_ep2;
  assign ep6_push_req = wr_act && adr_ep6;
  assign ep2_push     = HOST_OUT_VALID && HOST_OUT_READY;
  assign ep6_pop      = HOST_IN_VALID && HOST_IN_READY;

  assign underrun_set = ep2_pop_req && ep2_empty;
  // A host pop on the same edge makes room, so a write to a full EP6 is not an overrun then.
  assign overrun_set  = ep6_push_req && ep6_full && !ep6_pop;
  assign addr_set     = (rd_act && !adr_ep2) || (wr_act && !adr_ep6);

  assign fd_oe  = cs_act && !USB_SLOE && adr_ep2;
  assign USB_FD = fd_oe ? ep2_head : {DW{1'bz}};

  usb_sfifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_ep2 (
    .clk   (FPGA_GCLK1),
    .rst_n (CPU_RESET),
    .push  (ep2_push),
    .wdata (HOST_OUT_DATA),
    .pop   (ep2_pop_req),
    .rdata (ep2_head),
    .full  (ep2_full),
    .empty (ep2_empty),
    .count (ep2_count)
  );

  usb_sfifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_ep6 (
    .clk   (FPGA_GCLK1),
    .rst_n (CPU_RESET),
    .push  (ep6_push_req),
    .wdata (USB_FD),
    .pop   (ep6_pop),
    .rdata (HOST_IN_DATA),
    .full  (ep6_full),
    .empty (ep6_empty),
    .count (ep6_count)
  );

  // Flags decode the registered counts, so they move on the same edge as the count.
  assign USB_FLAGA      = !(ep6_count >= PfLevel);
  assign USB_FLAGB      = !ep6_full;
  assign USB_FLAGC      = (ep2_count != '0);
  assign HOST_OUT_READY = !ep2_full;
  assign HOST_IN_VALID  = !ep6_empty;
  assign ERR_STATUS     = err_q;

  always_ff @(posedge FPGA_GCLK1 or negedge CPU_RESET) begin
    if (!CPU_RESET) begin
      err_q <= '0;
    end else begin
      if (addr_set)     err_q.addr_err <= 1'b1;
      if (underrun_set) err_q.underrun <= 1'b1;
      if (overrun_set)  err_q.overrun  <= 1'b1;
    end
  end

endmodule
